// File: rtl/uart_frame_decoder.sv
// Assembles 5-byte command frames (SOF, OPCODE, A, B, CHK) from a UART byte stream,
// checks the XOR checksum and inter-byte timeout, and holds good commands behind valid/ready.
module uart_frame_decoder #(
  parameter int              DBIT           = 8,
  parameter logic [DBIT-1:0] SOF_BYTE       = 8'hA5,
  parameter int              TIMEOUT_CYCLES = 1000000,
  parameter int              TMO_W          = 20
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_done,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [DBIT-1:0] o_op,
  output logic [DBIT-1:0] o_a,
  output logic [DBIT-1:0] o_b,
  output logic            o_chk_err,
  output logic            o_timeout,
  output logic            o_ovf
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OP  = 3'd1,
    GET_A   = 3'd2,
    GET_B   = 3'd3,
    GET_CHK = 3'd4
  } state_t;

  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  function automatic logic [DBIT-1:0] frame_chk(input logic [DBIT-1:0] op,
                                                input logic [DBIT-1:0] a,
                                                input logic [DBIT-1:0] b);
    return op ^ a ^ b;
  endfunction

  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [DBIT-1:0]  op_stg, a_stg, b_stg;
  logic             tmo_expire;
  logic             load_cmd, set_chk, set_ovf;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_expire = TMO_EN && (state != IDLE) && !i_rx_done && (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tmo_expire) begin
      state_nxt = IDLE;
    end else if (i_rx_done) begin
      case (state)
        IDLE:    if (i_rx_data == SOF_BYTE) state_nxt = GET_OP;
        GET_OP:  state_nxt = GET_A;
        GET_A:   state_nxt = GET_B;
        GET_B:   state_nxt = GET_CHK;
        GET_CHK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    load_cmd = 1'b0;
    set_chk  = 1'b0;
    set_ovf  = 1'b0;
    if (state == GET_CHK && i_rx_done) begin
      if (frame_chk(op_stg, a_stg, b_stg) != i_rx_data) set_chk  = 1'b1;
      else if (o_valid && !i_ready)                     set_ovf  = 1'b1;
      else                                              load_cmd = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tmo_cnt <= '0;
    end else if (!TMO_EN || state == IDLE || i_rx_done || tmo_expire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Frame staging
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      op_stg <= '0;
      a_stg  <= '0;
      b_stg  <= '0;
    end else if (tmo_expire) begin
      op_stg <= '0;
      a_stg  <= '0;
      b_stg  <= '0;
    end else if (i_rx_done) begin
      if (state == GET_OP) op_stg <= i_rx_data;
      if (state == GET_A)  a_stg  <= i_rx_data;
      if (state == GET_B)  b_stg  <= i_rx_data;
    end
  end

  // Holding register and status pulses
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid   <= 1'b0;
      o_op      <= '0;
      o_a       <= '0;
      o_b       <= '0;
      o_chk_err <= 1'b0;
      o_timeout <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      if (load_cmd) begin
        o_valid <= 1'b1;
        o_op    <= op_stg;
        o_a     <= a_stg;
        o_b     <= b_stg;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      o_chk_err <= set_chk;
      o_timeout <= tmo_expire;
      o_ovf     <= set_ovf;
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomised and directed bench for uart_frame_decoder with a frame-level reference model
// feeding an event scoreboard that a separate monitor drains.
module tb_uart_frame_decoder;

  localparam int         TMO = 50;
  localparam logic [7:0] SOF = 8'hA5;
  localparam int EV_CMD = 0, EV_CHK = 1, EV_TMO = 2, EV_OVF = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rdy = 1'b0;
  logic       o_valid, o_chk_err, o_timeout, o_ovf;
  logic [7:0] o_op, o_a, o_b;

  uart_frame_decoder #(
    .DBIT(8), .SOF_BYTE(SOF), .TIMEOUT_CYCLES(TMO), .TMO_W(8)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_ready(rdy), .o_valid(o_valid), .o_op(o_op), .o_a(o_a), .o_b(o_b),
    .o_chk_err(o_chk_err), .o_timeout(o_timeout), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] op, a, b;
    int         n;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frm[$];
  int         last_n, edge_n, errs, checks;
  bit         held, rand_rdy, pv, pr;
  logic       rdy_hold = 1'b0;
  logic [7:0] held_op, held_a, held_b;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic void push_ev(int kind, logic [7:0] op, logic [7:0] a, logic [7:0] b);
    ev_t e;
    e.kind = kind; e.op = op; e.a = a; e.b = b; e.n = edge_n;
    exp_q.push_back(e);
  endfunction

  // Reference model: byte stream to frames, one call per clock edge.
  function automatic void model_edge(bit d, logic [7:0] b, bit r);
    bit load = 1'b0;
    if (frm.size() > 0 && !d && (edge_n - last_n) >= TMO) begin
      push_ev(EV_TMO, 8'h00, 8'h00, 8'h00);
      frm.delete();
    end
    if (d) begin
      if (frm.size() > 0 || b == SOF) begin
        frm.push_back(b);
        last_n = edge_n;
      end
      if (frm.size() == 5) begin
        if ((frm[1] ^ frm[2] ^ frm[3]) != frm[4]) push_ev(EV_CHK, 8'h00, 8'h00, 8'h00);
        else if (held && !r)                      push_ev(EV_OVF, 8'h00, 8'h00, 8'h00);
        else begin
          push_ev(EV_CMD, frm[1], frm[2], frm[3]);
          load = 1'b1;
        end
        frm.delete();
      end
    end
    if (load)   held = 1'b1;
    else if (r) held = 1'b0;
  endfunction

  function automatic void got(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", kind, edge_n);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_edge", edge_n, e.n);
      if (kind == EV_CMD) begin
        chk("cmd_op", o_op, e.op);
        chk("cmd_a", o_a, e.a);
        chk("cmd_b", o_b, e.b);
        held_op = o_op; held_a = o_a; held_b = o_b;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].n < edge_n) begin
        checks++;
        errs++;
        $display("FAIL missed_event: got none at edge %0d, expected kind %0d", exp_q[0].n, exp_q[0].kind);
        void'(exp_q.pop_front());
      end
      if (o_valid && (!pv || pr)) got(EV_CMD);
      if (o_chk_err) got(EV_CHK);
      if (o_timeout) got(EV_TMO);
      if (o_ovf)     got(EV_OVF);
      if (pv && !pr) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_stable", {o_op, o_a, o_b}, {held_op, held_a, held_b});
      end
      pv = o_valid;
      pr = rdy;
    end
  end

  task automatic cyc_step(bit d, logic [7:0] b);
    rx_done = d;
    rx_data = d ? b : 8'($urandom);
    rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_hold;
    @(posedge clk);
    edge_n++;
    if (rst_n) model_edge(d, b, rdy);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc_step(1'b0, 8'h00);
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    idle(gap);
    cyc_step(1'b1, b);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[k]) send_byte(bytes[k], 2);
  endtask

  task automatic consume();
    rdy_hold = 1'b1;
    idle(1);
    rdy_hold = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_outputs", {o_op, o_a, o_b}, 24'h0);
    chk("rst_pulses", {o_chk_err, o_timeout, o_ovf}, 3'b000);
    exp_q.delete();
    frm.delete();
    held = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 39) == 0) ? TMO + 5 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    #1;
    do_reset();

    // Plain frame, consumer stalled
    send_seq('{8'hA5, 8'h03, 8'h12, 8'h34, 8'h25});
    idle(1);
    chk("t1_valid", o_valid, 1);
    chk("t1_cmd", {o_op, o_a, o_b}, 24'h031234);
    consume();
    idle(1);
    chk("t1_consumed", o_valid, 0);

    // Leading junk, bad checksum, then a good frame left held
    send_seq('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h05});
    idle(1);
    chk("t2_no_valid", o_valid, 0);
    send_seq('{8'hA5, 8'h10, 8'h20, 8'h30, 8'h00});
    idle(1);
    chk("t2_good", {o_op, o_a, o_b}, 24'h102030);

    // Overflow while held, then replacement on the accept cycle
    send_seq('{8'hA5, 8'h44, 8'h55, 8'h66, 8'h77});
    idle(1);
    chk("t3_ovf_hold", {o_valid, o_op, o_a, o_b}, {1'b1, 24'h102030});
    send_seq('{8'hA5, 8'h44, 8'h55, 8'h66});
    rdy_hold = 1'b1;
    send_byte(8'h77, 0);
    rdy_hold = 1'b0;
    idle(1);
    chk("t3_replace", {o_valid, o_op, o_a, o_b}, {1'b1, 24'h445566});
    consume();

    // Inter-byte timeout, then recovery
    send_seq('{8'hA5, 8'h07});
    idle(60);
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01});
    idle(1);
    chk("t4_after_tmo", {o_valid, o_op, o_a, o_b}, {1'b1, 24'h010000});

    // Reset mid-frame with a command held, then headless bytes
    send_seq('{8'hA5, 8'h11});
    do_reset();
    send_seq('{8'h11, 8'h22, 8'h33, 8'h00});
    idle(5);
    chk("t5_no_sof", o_valid, 0);

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] f[5];
      if ($urandom_range(0, 7) == 0) begin
        send_byte(8'($urandom), rgap());
      end else begin
        f[0] = SOF;
        f[1] = 8'($urandom);
        f[2] = 8'($urandom);
        f[3] = 8'($urandom);
        f[4] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (f[1] ^ f[2] ^ f[3]);
        for (int k = 0; k < 5; k++) send_byte(f[k], rgap());
      end
    end
    rand_rdy = 1'b0;
    rdy_hold = 1'b1;
    idle(TMO + 10);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
